mac_array_arbiter: RTL and testbench

Arbitrates exclusive use of the 4-MAC array between two sequencing requesters: requester 0 is the valid-pipeline controller and requester 1 is the layering controller. Today their 12-bit `valid_ctrl` vectors are summed, so concurrent runs corrupt each other. This block sits between the two controllers and `mac_array`. It grants one job at a time, clears the accumulators before each job, forwards only the owner's `valid_ctrl`, waits for the array pipeline to drain, and signals completion.

---
 rtl/mac_array_arbiter.sv | 129 ++++++++++++
 tb/tb_mac_array_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_arbiter.sv
// Grants the 4-MAC array to one of two sequencing controllers at a time,
// clearing the accumulators first and forwarding only the owner's valid_ctrl.
module mac_array_arbiter #(
    parameter int N_MACS    = 4,
    parameter int CTRL_W    = 12,
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic [LEN_W-1:0]  len_0,
    input  logic [LEN_W-1:0]  len_1,
    input  logic [CTRL_W-1:0] ctrl_0,
    input  logic [CTRL_W-1:0] ctrl_1,
    input  logic              clear_ext,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              done_0,
    output logic              done_1,
    output logic [CTRL_W-1:0] valid_ctrl,
    output logic [N_MACS-1:0] clear,
    output logic              busy,
    output logic              owner
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic              rr_prio;
    logic              winner;
    logic [LEN_W-1:0]  run_cnt;
    logic [DW-1:0]     drain_cnt;

    // On a tie the pointer decides; it always names the requester not served last.
    always_comb begin
        winner = req_1;
        if (req_0 && req_1) begin
            winner = rr_prio;
        end
    end

    always_comb begin
        valid_ctrl = '0;
        if (state == RUN) begin
            valid_ctrl = owner ? ctrl_1 : ctrl_0;
        end
        clear = {N_MACS{clear_ext}};
        if (state == CLEAR) begin
            clear = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            rr_prio   <= 1'b0;
            run_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        owner   <= winner;
                        gnt_0   <= ~winner;
                        gnt_1   <= winner;
                        busy    <= 1'b1;
                        run_cnt <= winner ? len_1 : len_0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (run_cnt == '0) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt - LEN_W'(1);
                    if (run_cnt == LEN_W'(1)) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Grant drops together with the done pulse so DONE shows both grants low.
                    if (drain_cnt == '0) begin
                        gnt_0  <= 1'b0;
                        gnt_1  <= 1'b0;
                        done_0 <= ~owner;
                        done_1 <= owner;
                        state  <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    done_0  <= 1'b0;
                    done_1  <= 1'b0;
                    busy    <= 1'b0;
                    rr_prio <= ~owner;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_arbiter.sv
// Directed bench for mac_array_arbiter: each task drives one scenario and
// compares the full output bundle against hand-derived per-cycle values.
module tb_mac_array_arbiter;

    logic        clk;
    logic        rst;
    logic        req_0;
    logic        req_1;
    logic [7:0]  len_0;
    logic [7:0]  len_1;
    logic [11:0] ctrl_0;
    logic [11:0] ctrl_1;
    logic        clear_ext;
    logic        gnt_0;
    logic        gnt_1;
    logic        done_0;
    logic        done_1;
    logic [11:0] valid_ctrl;
    logic [3:0]  clear;
    logic        busy;
    logic        owner;

    int checks;
    int failures;

    logic [21:0] obs;
    assign obs = {gnt_0, gnt_1, done_0, done_1, busy, owner, clear, valid_ctrl};

    mac_array_arbiter #(
        .N_MACS(4),
        .CTRL_W(12),
        .LEN_W(8),
        .DRAIN_CYC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_0(req_0),
        .req_1(req_1),
        .len_0(len_0),
        .len_1(len_1),
        .ctrl_0(ctrl_0),
        .ctrl_1(ctrl_1),
        .clear_ext(clear_ext),
        .gnt_0(gnt_0),
        .gnt_1(gnt_1),
        .done_0(done_0),
        .done_1(done_1),
        .valid_ctrl(valid_ctrl),
        .clear(clear),
        .busy(busy),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bundle p cycles into a job (p=0 is CLEAR), DRAIN_CYC fixed at 3, clear_ext low.
    function automatic logic [21:0] exp_bundle(int p, bit own, int len, logic [11:0] ctrl);
        logic g, d, b;
        logic [3:0]  c;
        logic [11:0] v;
        g = (p <= len + 3);
        d = (p == len + 4);
        b = (p <= len + 4);
        c = (p == 0) ? 4'hF : 4'h0;
        v = (p >= 1 && p <= len) ? ctrl : 12'h000;
        return {g & ~own, g & own, d & ~own, d & own, b, own, c, v};
    endfunction

    task automatic do_reset();
        req_0 = 0; req_1 = 0; len_0 = 0; len_1 = 0;
        ctrl_0 = 0; ctrl_1 = 0; clear_ext = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_0 = 1; req_1 = 1; len_0 = 8'd4; len_1 = 8'd4;
        ctrl_0 = 12'hABC; ctrl_1 = 12'h123; clear_ext = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold got=%h exp=%h", obs, 22'h0);
        end
        clear_ext = 1;
        #1;
        checks++;
        if (obs !== {6'b0, 4'hF, 12'h000}) begin
            failures++;
            $display("[TB] FAIL reset_clear_ext got=%h exp=%h", obs, {6'b0, 4'hF, 12'h000});
        end
        req_0 = 0; req_1 = 0; clear_ext = 0;
        rst = 0;
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("[TB] FAIL reset_idle got=%h exp=%h", obs, 22'h0);
        end
    endtask

    task automatic test_single_job();
        logic [21:0] e;
        req_0 = 1; len_0 = 8'd5; ctrl_0 = 12'h00F;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            e = exp_bundle(k - 1, 1'b0, 5, 12'h00F);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL single_job k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 10) req_0 = 0;
        end
    endtask

    // Leaves the pointer favouring requester 1, so the tie after reset checks that reset restores it.
    task automatic test_abort();
        logic [21:0] e;
        req_0 = 1; len_0 = 8'd5; ctrl_0 = 12'h123;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = exp_bundle(k - 1, 1'b0, 5, 12'h123);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL abort_run k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        rst = 1; req_0 = 0;
        @(negedge clk);
        rst = 0;
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (obs !== 22'h0) begin
                failures++;
                $display("[TB] FAIL abort_idle k=%0d got=%h exp=%h", k, obs, 22'h0);
            end
            @(negedge clk);
        end
        req_0 = 1; req_1 = 1; len_0 = 8'd1; len_1 = 8'd1;
        ctrl_0 = 12'h00A; ctrl_1 = 12'h0F0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            e = exp_bundle((k - 1) % 7, ((k - 1) / 7) % 2 == 1, 1,
                           ((k - 1) / 7) % 2 == 1 ? 12'h0F0 : 12'h00A);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL abort_rearm k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        req_0 = 0; req_1 = 0;
        repeat (8) @(negedge clk);
    endtask

    // Both held: jobs alternate 0,1,0,1; owner's len is scribbled after grant and must be ignored.
    task automatic test_simultaneous();
        logic [21:0] e;
        int p;
        bit own;
        do_reset();
        req_0 = 1; req_1 = 1; len_0 = 8'd2; len_1 = 8'd2;
        ctrl_0 = 12'h3C3; ctrl_1 = 12'hFFF;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            p = (k - 1) % 8;
            own = ((k - 1) / 8) % 2 == 1;
            e = exp_bundle(p, own, 2, own ? 12'hFFF : 12'h3C3);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL simultaneous k=%0d got=%h exp=%h", k, obs, e);
            end
            if (p == 1) begin
                if (own) len_1 = 8'd9; else len_0 = 8'd9;
            end
            if (p == 6) begin
                len_0 = 8'd2; len_1 = 8'd2;
            end
        end
        req_0 = 0; req_1 = 0;
        @(negedge clk);
        checks++;
        if (obs !== {5'b0, 1'b1, 16'h0}) begin
            failures++;
            $display("[TB] FAIL simultaneous_end got=%h exp=%h", obs, {5'b0, 1'b1, 16'h0});
        end
    endtask

    task automatic test_len_zero();
        logic [21:0] e;
        do_reset();
        req_1 = 1; len_1 = 8'd0; ctrl_1 = 12'hFFF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = exp_bundle(k - 1, 1'b1, 0, 12'hFFF);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL len_zero k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 5) req_1 = 0;
        end
    endtask

    task automatic test_clear_ext();
        logic [21:0] e;
        do_reset();
        req_0 = 1; len_0 = 8'd3; ctrl_0 = 12'h5A5;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e = exp_bundle(k - 1, 1'b0, 3, 12'h5A5);
            if (k == 2) e[15:12] = 4'hF;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL clear_ext k=%0d got=%h exp=%h", k, obs, e);
            end
            clear_ext = (k == 1);
            if (k == 8) req_0 = 0;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_job();
        test_abort();
        test_simultaneous();
        test_len_zero();
        test_clear_ext();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
